// File: rtl/pbvi_pkg.sv
// rtl/pbvi_pkg.sv - shared PBVI types, FSM states and width helpers
package pbvi_pkg;

  // Fixed-point element shared by the PBVI steps (belief and alpha entries)
  localparam int FIX_W = 16;
  typedef logic [FIX_W-1:0] fix_t;

  // Backup-stage controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of an action index; a single action still needs one bit
  function automatic int pbvi_act_w(input int n_actions);
    return (n_actions <= 1) ? 1 : $clog2(n_actions);
  endfunction

  // Width of a full-precision unsigned dot product of n_states elements
  function automatic int pbvi_val_w(input int data_w, input int n_states);
    return 2 * data_w + $clog2(n_states) + 1;
  endfunction

endpackage

// File: rtl/pbvi_dot.sv
// rtl/pbvi_dot.sv - combinational unsigned dot product of one belief and one alpha vector
module pbvi_dot
  import pbvi_pkg::*;
#(
  parameter int N_STATES = 2,
  parameter int DATA_W   = 16,
  localparam int VAL_W   = pbvi_val_w(DATA_W, N_STATES)
) (
  input  logic [N_STATES-1:0][DATA_W-1:0] belief_i,
  input  logic [N_STATES-1:0][DATA_W-1:0] alpha_i,
  output logic [VAL_W-1:0]                val_o
);

  // Accumulate full-width products; VAL_W leaves room for every carry
  always_comb begin
    val_o = '0;
    for (int s = 0; s < N_STATES; s++) begin
      val_o = val_o + VAL_W'(belief_i[s]) * VAL_W'(alpha_i[s]);
    end
  end

endmodule

// File: rtl/pbvi_alpha_select.sv
// rtl/pbvi_alpha_select.sv - PBVI backup argmax over actions, one action per cycle; optional PBVI_ALPHA_VALUE_OUT_EN adds max_val_o
module pbvi_alpha_select
  import pbvi_pkg::*;
#(
  parameter int N_POINTS  = 16,
  parameter int N_ACTIONS = 3,
  parameter int N_STATES  = 2,
  parameter int DATA_W    = 16,
  localparam int ACT_W    = pbvi_act_w(N_ACTIONS),
  localparam int VAL_W    = pbvi_val_w(DATA_W, N_STATES)
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   start,
  input  logic [N_ACTIONS-1:0][N_POINTS-1:0][N_STATES-1:0][DATA_W-1:0] gamma_action_belief,
  input  logic [N_POINTS-1:0][N_STATES-1:0][DATA_W-1:0]          point_belief,
  output logic                                                   busy,
  output logic                                                   done,
  output logic [N_POINTS-1:0][ACT_W-1:0]                         point_action,
`ifdef PBVI_ALPHA_VALUE_OUT_EN
  output logic [N_POINTS-1:0][N_STATES-1:0][DATA_W-1:0]          alpha,
  output logic [N_POINTS-1:0][VAL_W-1:0]                         max_val_o
`else
  output logic [N_POINTS-1:0][N_STATES-1:0][DATA_W-1:0]          alpha
`endif
);

  localparam logic [ACT_W-1:0] ACT_LAST = ACT_W'(N_ACTIONS - 1);

  state_e                                         state_q, state_d;
  logic [ACT_W-1:0]                               act_idx_q, act_idx_d;
  logic [N_POINTS-1:0][VAL_W-1:0]                 max_val_q, max_val_d;
  logic [N_POINTS-1:0][N_STATES-1:0][DATA_W-1:0]  alpha_q, alpha_d;
  logic [N_POINTS-1:0][ACT_W-1:0]                 action_q, action_d;
  logic [N_POINTS-1:0][VAL_W-1:0]                 val;

  // One dot-product unit per point, all fed the currently indexed action
  for (genvar p = 0; p < N_POINTS; p++) begin : g_dot
    pbvi_dot #(
      .N_STATES(N_STATES),
      .DATA_W  (DATA_W)
    ) u_dot (
      .belief_i(point_belief[p]),
      .alpha_i (gamma_action_belief[act_idx_q][p]),
      .val_o   (val[p])
    );
  end

  // Controller next state: sweep every action once, then flag completion
  always_comb begin
    state_d   = state_q;
    act_idx_d = act_idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = EVAL;
          act_idx_d = '0;
        end
      end
      EVAL: begin
        if (act_idx_q == ACT_LAST) begin
          state_d   = DONE;
          act_idx_d = '0;
        end else begin
          act_idx_d = act_idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Running argmax: first action seeds, later ones replace only on a strict win
  always_comb begin
    max_val_d = max_val_q;
    alpha_d   = alpha_q;
    action_d  = action_q;
    if (state_q == EVAL) begin
      for (int p = 0; p < N_POINTS; p++) begin
        if (act_idx_q == '0 || val[p] > max_val_q[p]) begin
          max_val_d[p] = val[p];
          alpha_d[p]   = gamma_action_belief[act_idx_q][p];
          action_d[p]  = act_idx_q;
        end
      end
    end
  end

  // State and result registers; reset discards any partial run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      act_idx_q <= '0;
      max_val_q <= '0;
      alpha_q   <= '0;
      action_q  <= '0;
    end else begin
      state_q   <= state_d;
      act_idx_q <= act_idx_d;
      max_val_q <= max_val_d;
      alpha_q   <= alpha_d;
      action_q  <= action_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign point_action = action_q;
  assign alpha        = alpha_q;

`ifdef PBVI_ALPHA_VALUE_OUT_EN
  assign max_val_o = max_val_q;
`endif

endmodule

// File: tb/tb_pbvi_alpha_select.sv
// tb/tb_pbvi_alpha_select.sv - randomized self-checking bench for pbvi_alpha_select against an argmax model
module tb_pbvi_alpha_select;

  localparam int P1 = 16, A1 = 3, S1 = 2;
  localparam int P2 = 4,  A2 = 5, S2 = 3;
  localparam int W  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start1 = 1'b0, start2 = 1'b0;

  always #5 clk = ~clk;

  logic [A1-1:0][P1-1:0][S1-1:0][W-1:0] g1;
  logic [P1-1:0][S1-1:0][W-1:0]         b1;
  logic                                 busy1, done1;
  logic [P1-1:0][1:0]                   pa1;
  logic [P1-1:0][S1-1:0][W-1:0]         al1;

  logic [A2-1:0][P2-1:0][S2-1:0][W-1:0] g2;
  logic [P2-1:0][S2-1:0][W-1:0]         b2;
  logic                                 busy2, done2;
  logic [P2-1:0][2:0]                   pa2;
  logic [P2-1:0][S2-1:0][W-1:0]         al2;

`ifdef PBVI_ALPHA_VALUE_OUT_EN
  logic [P1-1:0][33:0] mv1;
  logic [P2-1:0][34:0] mv2;
`endif

  pbvi_alpha_select #(.N_POINTS(P1), .N_ACTIONS(A1), .N_STATES(S1), .DATA_W(W)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .gamma_action_belief(g1), .point_belief(b1),
    .busy(busy1), .done(done1), .point_action(pa1), .alpha(al1)
`ifdef PBVI_ALPHA_VALUE_OUT_EN
    , .max_val_o(mv1)
`endif
  );

  pbvi_alpha_select #(.N_POINTS(P2), .N_ACTIONS(A2), .N_STATES(S2), .DATA_W(W)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .gamma_action_belief(g2), .point_belief(b2),
    .busy(busy2), .done(done2), .point_action(pa2), .alpha(al2)
`ifdef PBVI_ALPHA_VALUE_OUT_EN
    , .max_val_o(mv2)
`endif
  );

  // Reference data: beliefs mb[p][s], candidate alphas mg[a][p][s]
  longint unsigned mb [16][3];
  longint unsigned mg [5][16][3];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned dotv(input int a, input int p, input int ns);
    longint unsigned acc = 0;
    for (int s = 0; s < ns; s++) acc += mb[p][s] * mg[a][p][s];
    return acc;
  endfunction

  // Argmax with ties going to the lowest action index
  function automatic int golden(input int p, input int na, input int ns);
    int best = 0;
    for (int a = 1; a < na; a++)
      if (dotv(a, p, ns) > dotv(best, p, ns)) best = a;
    return best;
  endfunction

  function automatic longint unsigned rnd();
    if ($urandom_range(0, 1) == 1) return longint'($urandom_range(0, 3));
    return longint'($urandom_range(0, 65535));
  endfunction

  task automatic randomize_model();
    for (int p = 0; p < 16; p++)
      for (int s = 0; s < 3; s++) begin
        mb[p][s] = rnd();
        for (int a = 0; a < 5; a++) mg[a][p][s] = rnd();
      end
  endtask

  task automatic drive();
    for (int p = 0; p < P1; p++)
      for (int s = 0; s < S1; s++) begin
        b1[p][s] = 16'(mb[p][s]);
        for (int a = 0; a < A1; a++) g1[a][p][s] = 16'(mg[a][p][s]);
      end
    for (int p = 0; p < P2; p++)
      for (int s = 0; s < S2; s++) begin
        b2[p][s] = 16'(mb[p][s]);
        for (int a = 0; a < A2; a++) g2[a][p][s] = 16'(mg[a][p][s]);
      end
  endtask

  task automatic check1(input string tag);
    logic [S1-1:0][W-1:0] ea;
    int act;
    for (int p = 0; p < P1; p++) begin
      act = golden(p, A1, S1);
      for (int s = 0; s < S1; s++) ea[s] = 16'(mg[act][p][s]);
      check($sformatf("%s_act%0d", tag, p), 64'(pa1[p]), 64'(act));
      check($sformatf("%s_alpha%0d", tag, p), 64'(al1[p]), 64'(ea));
`ifdef PBVI_ALPHA_VALUE_OUT_EN
      check($sformatf("%s_val%0d", tag, p), 64'(mv1[p]), 64'(dotv(act, p, S1)));
`endif
    end
  endtask

  task automatic check2(input string tag);
    logic [S2-1:0][W-1:0] ea;
    int act;
    for (int p = 0; p < P2; p++) begin
      act = golden(p, A2, S2);
      for (int s = 0; s < S2; s++) ea[s] = 16'(mg[act][p][s]);
      check($sformatf("%s_act%0d", tag, p), 64'(pa2[p]), 64'(act));
      check($sformatf("%s_alpha%0d", tag, p), 64'(al2[p]), 64'(ea));
`ifdef PBVI_ALPHA_VALUE_OUT_EN
      check($sformatf("%s_val%0d", tag, p), 64'(mv2[p]), 64'(dotv(act, p, S2)));
`endif
    end
  endtask

  // Pulse start for one edge; lat is the cycle (1 = first after the start edge) where done is seen
  task automatic run1(output int lat, output int bcnt);
    lat = -1; bcnt = 0;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (busy1) bcnt++;
      if (done1) begin lat = c; break; end
      @(negedge clk);
    end
  endtask

  task automatic run2(output int lat, output int bcnt);
    lat = -1; bcnt = 0;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (busy2) bcnt++;
      if (done2) begin lat = c; break; end
      @(negedge clk);
    end
  endtask

  initial begin
    int lat, bc, ndone, exp_n;
    int dq[$];

    for (int p = 0; p < 16; p++)
      for (int s = 0; s < 3; s++) begin
        mb[p][s] = 0;
        for (int a = 0; a < 5; a++) mg[a][p][s] = 0;
      end
    drive();
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy1), 64'd0);
    check("rst_done", 64'(done1), 64'd0);
    check("rst_action", 64'(pa1), 64'd0);
    check("rst_alpha", 64'(|al1), 64'd0);
    rst_n = 1'b1;

    // Directed: belief (1,2); values 9, 7, 11 -> action 2
    randomize_model();
    mb[0][0] = 1; mb[0][1] = 2;
    mg[0][0][0] = 3; mg[0][0][1] = 3;
    mg[1][0][0] = 5; mg[1][0][1] = 1;
    mg[2][0][0] = 1; mg[2][0][1] = 5;
    drive();
    run1(lat, bc);
    check("dir_latency", 64'(lat), 64'(A1 + 1));
    check("dir_busy_cycles", 64'(bc), 64'(A1 + 1));
    check("dir_p0_action", 64'(pa1[0]), 64'd2);
    check("dir_p0_alpha", 64'(al1[0]), {32'd0, 16'd5, 16'd1});
    check1("dir");

    // Three-way tie at value 4 -> lowest index wins
    mb[0][0] = 1; mb[0][1] = 1;
    mg[0][0][0] = 2; mg[0][0][1] = 2;
    mg[1][0][0] = 3; mg[1][0][1] = 1;
    mg[2][0][0] = 0; mg[2][0][1] = 4;
    drive();
    run1(lat, bc);
    check("tie_latency", 64'(lat), 64'(A1 + 1));
    check("tie_p0_action", 64'(pa1[0]), 64'd0);
    check("tie_p0_alpha", 64'(al1[0]), {32'd0, 16'd2, 16'd2});
    check1("tie");

    // Width extremes: only action 1 carries all-ones entries
    for (int p = 0; p < 16; p++)
      for (int s = 0; s < 3; s++) begin
        mb[p][s] = 64'hFFFF;
        for (int a = 0; a < 5; a++) mg[a][p][s] = (a == 1) ? 64'hFFFF : 64'd0;
      end
    drive();
    run1(lat, bc);
    check("ext_p0_action", 64'(pa1[0]), 64'd1);
`ifdef PBVI_ALPHA_VALUE_OUT_EN
    check("ext_p0_val", 64'(mv1[0]), 64'h1_FFFC_0002);
`endif
    check1("ext");

    // Reset after the first EVAL update: nothing flagged, outputs cleared
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy1), 64'd0);
    check("mid_rst_done", 64'(done1), 64'd0);
    check("mid_rst_action", 64'(pa1), 64'd0);
    check("mid_rst_alpha", 64'(|al1), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done1) ndone++;
    end
    check("mid_rst_no_done", 64'(ndone), 64'd0);
    randomize_model();
    drive();
    run1(lat, bc);
    check("post_rst_latency", 64'(lat), 64'(A1 + 1));
    check1("post_rst");

    // Random runs, default configuration
    for (int r = 0; r < 4; r++) begin
      randomize_model();
      drive();
      run1(lat, bc);
      check($sformatf("rnd1_latency%0d", r), 64'(lat), 64'(A1 + 1));
      check1($sformatf("rnd1_%0d", r));
    end

    // Random runs, 4 points / 5 actions / 3 states
    for (int r = 0; r < 5; r++) begin
      randomize_model();
      drive();
      run2(lat, bc);
      check($sformatf("rnd2_latency%0d", r), 64'(lat), 64'(A2 + 1));
      check($sformatf("rnd2_busy%0d", r), 64'(bc), 64'(A2 + 1));
      check2($sformatf("rnd2_%0d", r));
    end

    // Second start pulse during EVAL must be ignored
    randomize_model();
    drive();
    @(negedge clk);
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      start1 = (c == 0 || c == 2);
      @(negedge clk);
      if (done1) ndone++;
    end
    start1 = 1'b0;
    check("pulse_done_count", 64'(ndone), 64'd1);
    check1("pulse");

    // start held for 12 cycles: runs back-to-back with one idle cycle between
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      start1 = (c < 12);
      @(negedge clk);
      if (done1) dq.push_back(c + 1);
    end
    start1 = 1'b0;
    exp_n = 0;
    for (int k = 0; k * (A1 + 2) < 12; k++) exp_n++;
    check("held_done_count", 64'(dq.size()), 64'(exp_n));
    for (int k = 0; k < exp_n && k < dq.size(); k++)
      check($sformatf("held_done_cycle%0d", k), 64'(dq[k]), 64'(A1 + 1 + k * (A1 + 2)));
    check1("held");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
